// File: rtl/bmem_line_responder_pkg.sv
// Shared definitions for the bmem line responder.
//   state_e    : responder FSM states
//   BEATS      : beats per cache line (4)
//   LINE_OFF   : byte-offset bits inside one line (5 -> 32-byte line)
//   align_line : clears the line-offset bits of a byte address
package bmem_line_pkg;

  localparam int BEATS      = 4;
  localparam int LINE_OFF   = 5;
  localparam int BEAT_IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WCOLLECT = 3'd1,
    WCOMMIT  = 3'd2,
    RFETCH   = 3'd3,
    RWAIT    = 3'd4,
    RSTREAM  = 3'd5
  } state_e;

  function automatic logic [31:0] align_line(input logic [31:0] addr);
    return {addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
  endfunction

endpackage

// File: rtl/bmem_line_responder_if.sv
// Bus bundle between a bmem requester, the line responder and its
// backing store.
//
// Handshake rules:
//   bmem side  : a read request or write beat is accepted on a rising clk
//                edge where bmem_ready=1 and bmem_read/bmem_write is high.
//                Read beats are pushed with bmem_rvalid (no back-pressure);
//                bmem_rdata is zero whenever bmem_rvalid=0.
//   line side  : line_req (with line_we/line_addr/line_wdata) is held stable
//                until an edge where line_gnt=1. For reads, line_rdata is
//                taken on the edge where line_rvalid=1 (possibly the same
//                edge as line_gnt).
//
// Modports:
//   slave  : the responder
//   master : the requester plus backing store (testbench side)
interface bmem_line_responder_if #(
  parameter int BEAT_W = 64
);
  logic [31:0]         bmem_addr;
  logic                bmem_read;
  logic                bmem_write;
  logic [BEAT_W-1:0]   bmem_wdata;
  logic                bmem_ready;
  logic [31:0]         bmem_raddr;
  logic [BEAT_W-1:0]   bmem_rdata;
  logic                bmem_rvalid;

  logic                line_req;
  logic                line_we;
  logic [31:0]         line_addr;
  logic [4*BEAT_W-1:0] line_wdata;
  logic                line_gnt;
  logic                line_rvalid;
  logic [4*BEAT_W-1:0] line_rdata;

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    output line_req, line_we, line_addr, line_wdata,
    input  line_gnt, line_rvalid, line_rdata
  );

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
    input  line_req, line_we, line_addr, line_wdata,
    output line_gnt, line_rvalid, line_rdata
  );

endinterface

// File: rtl/bmem_line_responder_beat_mux.sv
// line_beat_mux: selects one BEAT_W slice out of a full line.
//   line     : BEATS*BEAT_W line, slot k = line[k*BEAT_W +: BEAT_W]
//   beat_idx : slot to select
//   beat     : selected slice
module line_beat_mux
  import bmem_line_pkg::*;
#(
  parameter int BEAT_W = 64
) (
  input  logic [BEATS*BEAT_W-1:0] line,
  input  logic [BEAT_IDX_W-1:0]   beat_idx,
  output logic [BEAT_W-1:0]       beat
);

  assign beat = line[int'(beat_idx)*BEAT_W +: BEAT_W];

endmodule

// File: rtl/bmem_line_responder.sv
// bmem_line_responder: converts 4-beat bmem bursts into whole-line
// backing-store transactions.
//   Writes: four beats (gaps allowed) are assembled into one line, then
//           committed with a single line_req/line_we request.
//   Reads : one read request fetches a line, which is streamed back as
//           four consecutive bmem_rvalid beats.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bmem_line_responder_if.slave (bmem and line channels)
//   dbg_state  : current FSM state, for observation only
// Configuration:
//   BMEM_LINE_RESPONDER_WRAP_EN defined   -> read beats critical-word-first,
//                                            starting at addr[4:3]
//   BMEM_LINE_RESPONDER_WRAP_EN undefined -> read beats in order 0,1,2,3
module bmem_line_responder
  import bmem_line_pkg::*;
#(
  parameter int BEAT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bmem_line_responder_if.slave  bus,
  output state_e                dbg_state
);

  localparam int LINE_W = BEATS * BEAT_W;

  state_e                  state_q, state_d;
  logic [31:0]             addr_q;
  // One line buffer serves both write assembly and read capture; the two
  // uses never overlap.
  logic [LINE_W-1:0]       line_q;
  logic [BEAT_IDX_W-1:0]   cnt_q;
  logic [BEAT_IDX_W-1:0]   beat_q;
  logic [BEAT_IDX_W-1:0]   start_q;
  logic [BEAT_IDX_W-1:0]   beat_sel;
  logic [BEAT_W-1:0]       mux_beat;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d         = state_q;
    bus.bmem_ready  = 1'b0;
    bus.bmem_rvalid = 1'b0;
    bus.line_req    = 1'b0;
    bus.line_we     = 1'b0;
    case (state_q)
      IDLE: begin
        bus.bmem_ready = 1'b1;
        // Write wins over a simultaneous read; the read is dropped.
        if (bus.bmem_write) begin
          state_d = WCOLLECT;
        end else if (bus.bmem_read) begin
          state_d = RFETCH;
        end
      end
      WCOLLECT: begin
        bus.bmem_ready = 1'b1;
        if (bus.bmem_write && (cnt_q == 2'd3)) begin
          state_d = WCOMMIT;
        end
      end
      WCOMMIT: begin
        bus.line_req = 1'b1;
        bus.line_we  = 1'b1;
        if (bus.line_gnt) begin
          state_d = IDLE;
        end
      end
      RFETCH: begin
        bus.line_req = 1'b1;
        if (bus.line_gnt) begin
          // A store that answers in the grant cycle skips RWAIT.
          state_d = bus.line_rvalid ? RSTREAM : RWAIT;
        end
      end
      RWAIT: begin
        if (bus.line_rvalid) begin
          state_d = RSTREAM;
        end
      end
      RSTREAM: begin
        bus.bmem_rvalid = 1'b1;
        if (beat_q == 2'd3) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: address latch, line buffer, beat counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      start_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.bmem_write) begin
            addr_q               <= align_line(bus.bmem_addr);
            line_q[BEAT_W-1:0]   <= bus.bmem_wdata;
            cnt_q                <= 2'd1;
          end else if (bus.bmem_read) begin
            addr_q <= align_line(bus.bmem_addr);
            beat_q <= '0;
`ifdef BMEM_LINE_RESPONDER_WRAP_EN
            start_q <= bus.bmem_addr[4:3];
`else
            start_q <= '0;
`endif
          end
        end
        WCOLLECT: begin
          if (bus.bmem_write) begin
            line_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= bus.bmem_wdata;
            cnt_q                                <= cnt_q + 2'd1;
          end
        end
        RFETCH: begin
          if (bus.line_gnt && bus.line_rvalid) begin
            line_q <= bus.line_rdata;
          end
        end
        RWAIT: begin
          if (bus.line_rvalid) begin
            line_q <= bus.line_rdata;
          end
        end
        RSTREAM: begin
          beat_q <= beat_q + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Beat index wraps mod 4 from the start beat.
  assign beat_sel = start_q + beat_q;

  line_beat_mux #(
    .BEAT_W (BEAT_W)
  ) u_beat_mux (
    .line     (line_q),
    .beat_idx (beat_sel),
    .beat     (mux_beat)
  );

  assign bus.bmem_rdata = bus.bmem_rvalid ? mux_beat : '0;
  assign bus.bmem_raddr = bus.bmem_rvalid ? addr_q : 32'd0;
  assign bus.line_addr  = bus.line_req ? addr_q : 32'd0;
  assign bus.line_wdata = (state_q == WCOMMIT) ? line_q : '0;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_bmem_line_responder.sv
module tb_bmem_line_responder;
  import bmem_line_pkg::*;

  localparam int BEAT_W = 64;
  localparam int LINE_W = 4 * BEAT_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bmem_line_responder_if #(.BEAT_W(BEAT_W)) bus ();
  state_e dbg_state;

  bmem_line_responder #(.BEAT_W(BEAT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [BEAT_W-1:0] exp_q[$];
  logic [LINE_W-1:0] mem [int unsigned];
  int commit_cnt = 0;
  int rvalid_cnt = 0;

  always @(posedge clk) begin
    if (bus.line_req === 1'b1 && bus.line_we === 1'b1 && bus.line_gnt === 1'b1) commit_cnt++;
    if (bus.bmem_rvalid === 1'b1) rvalid_cnt++;
  end

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    return {$urandom, $urandom};
  endfunction

  // First beat returned for a read request at this address.
  function automatic int expected_start(input logic [31:0] a);
`ifdef BMEM_LINE_RESPONDER_WRAP_EN
    return int'(a[4:3]);
`else
    return 0;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [BEAT_W-1:0] beats[4],
                          input int gaps[4], input int gnt_delay, input bit with_read,
                          input string tag);
    logic [LINE_W-1:0] exp_line;
    logic [31:0] a;
    int c0, held;
    bit done;
    a = {addr[31:5], 5'b0};
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    c0 = commit_cnt;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        bus.bmem_write = 1'b0;
        bus.bmem_wdata = rand_beat();
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.bmem_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_gap_ready: got %0b want 1", tag, bus.bmem_ready);
        end
      end
      bus.bmem_write = 1'b1;
      bus.bmem_wdata = beats[i];
      bus.bmem_addr  = (i == 0) ? addr : $urandom;
      bus.bmem_read  = with_read && (i == 0);
      @(posedge clk);
      #1;
    end
    bus.bmem_write = 1'b0;
    bus.bmem_read  = 1'b0;
    bus.bmem_wdata = rand_beat();
    mem[int'(a)] = exp_line;
    held = 0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (bus.line_req !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_commit_start: line_req got %0b want 1", tag, bus.line_req);
        end
      end
      if (bus.line_req === 1'b1) begin
        n_cmp++;
        if (bus.line_we !== 1'b1 || bus.line_addr !== a || bus.line_wdata !== exp_line ||
            bus.bmem_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_commit: we=%0b addr=%h ready=%0b data=%h want we=1 addr=%h ready=0 data=%h",
                   tag, bus.line_we, bus.line_addr, bus.bmem_ready, bus.line_wdata, a, exp_line);
        end
        if (held == gnt_delay) begin
          bus.line_gnt = 1'b1;
          @(posedge clk);
          #1;
          bus.line_gnt = 1'b0;
          done = 1'b1;
        end
        held++;
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_commit_timeout: no line_req within 50 cycles", tag);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.line_req !== 1'b0 || bus.bmem_ready !== 1'b1 || (commit_cnt - c0) != 1) begin
      n_fail++;
      $display("FAIL %s_after_commit: line_req=%0b ready=%0b commits=%0d want 0 1 1",
               tag, bus.line_req, bus.bmem_ready, commit_cnt - c0);
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input int gnt_delay, input int rv_delay,
                         input bit same_cycle, input string tag);
    logic [31:0] a;
    logic [LINE_W-1:0] line;
    logic [BEAT_W-1:0] exp;
    int st, held;
    bit done;
    a = {addr[31:5], 5'b0};
    if (!mem.exists(int'(a))) mem[int'(a)] = rand_line();
    line = mem[int'(a)];
    st = expected_start(addr);
    for (int k = 0; k < 4; k++) exp_q.push_back(line[((st + k) % 4)*BEAT_W +: BEAT_W]);
    bus.bmem_read = 1'b1;
    bus.bmem_addr = addr;
    @(posedge clk);
    #1;
    bus.bmem_read = 1'b0;
    bus.bmem_addr = $urandom;
    held = 0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.line_req === 1'b1) begin
        n_cmp++;
        if (bus.line_we !== 1'b0 || bus.line_addr !== a || bus.bmem_ready !== 1'b0 ||
            bus.bmem_rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_fetch: we=%0b addr=%h ready=%0b rvalid=%0b want we=0 addr=%h ready=0 rvalid=0",
                   tag, bus.line_we, bus.line_addr, bus.bmem_ready, bus.bmem_rvalid, a);
        end
        if (held == gnt_delay) begin
          bus.line_gnt = 1'b1;
          if (same_cycle) begin
            bus.line_rvalid = 1'b1;
            bus.line_rdata  = line;
          end
          @(posedge clk);
          #1;
          bus.line_gnt    = 1'b0;
          bus.line_rvalid = 1'b0;
          bus.line_rdata  = rand_line();
          done = 1'b1;
        end
        held++;
      end
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_fetch_timeout: no line_req within 50 cycles", tag);
    end
    if (!same_cycle) begin
      for (int k = 0; k < rv_delay; k++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.bmem_rvalid !== 1'b0 || bus.bmem_rdata !== '0 || bus.line_req !== 1'b0 ||
            bus.bmem_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_wait: rvalid=%0b rdata=%h line_req=%0b ready=%0b want 0 0 0 0",
                   tag, bus.bmem_rvalid, bus.bmem_rdata, bus.line_req, bus.bmem_ready);
        end
      end
      bus.line_rvalid = 1'b1;
      bus.line_rdata  = line;
      @(posedge clk);
      #1;
      bus.line_rvalid = 1'b0;
      bus.line_rdata  = rand_line();
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.bmem_rvalid !== 1'b1 || bus.bmem_rdata !== exp || bus.bmem_raddr !== a ||
          bus.bmem_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_beat%0d: rvalid=%0b rdata=%h raddr=%h ready=%0b want 1 %h %h 0",
                 tag, k, bus.bmem_rvalid, bus.bmem_rdata, bus.bmem_raddr, bus.bmem_ready, exp, a);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.bmem_rvalid !== 1'b0 || bus.bmem_rdata !== '0 || bus.bmem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end: rvalid=%0b rdata=%h ready=%0b want 0 0 1",
               tag, bus.bmem_rvalid, bus.bmem_rdata, bus.bmem_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.bmem_ready !== 1'b1 || bus.bmem_rvalid !== 1'b0 || bus.bmem_rdata !== '0 ||
        bus.bmem_raddr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bmem: ready=%0b rvalid=%0b rdata=%h raddr=%h want 1 0 0 0",
               bus.bmem_ready, bus.bmem_rvalid, bus.bmem_rdata, bus.bmem_raddr);
    end
    n_cmp++;
    if (bus.line_req !== 1'b0 || bus.line_we !== 1'b0 || bus.line_addr !== 32'd0 ||
        bus.line_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_line: req=%0b we=%0b addr=%h wdata=%h want 0 0 0 0",
               bus.line_req, bus.line_we, bus.line_addr, bus.line_wdata);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== IDLE || bus.bmem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d ready=%0b want IDLE 1", dbg_state, bus.bmem_ready);
    end
  endtask

  task automatic test_write();
    logic [BEAT_W-1:0] b[4];
    b = '{{8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}};
    sync();
    do_write(32'h0000_1040, b, '{0, 0, 0, 0}, 3, 1'b0, "write");
  endtask

  task automatic test_read();
    logic [LINE_W-1:0] l;
    l = rand_line();
    mem[32'h0000_2000] = l;
    sync();
    do_read(32'h0000_2000, 1, 2, 1'b0, "read");
  endtask

  task automatic test_wrap();
    sync();
    do_read(32'h0000_2010, 0, 0, 1'b0, "wrap");
    sync();
    do_read(32'h0000_2018, 2, 1, 1'b1, "wrap_same");
  endtask

  task automatic test_write_gaps();
    logic [BEAT_W-1:0] b[4];
    b = '{{8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}}};
    sync();
    do_write(32'h0000_1040, b, '{0, 0, 2, 0}, 0, 1'b0, "write_gap");
  endtask

  task automatic test_simultaneous();
    logic [BEAT_W-1:0] b[4];
    int r0;
    for (int i = 0; i < 4; i++) b[i] = rand_beat();
    r0 = rvalid_cnt;
    sync();
    do_write(32'h0000_4000, b, '{0, 0, 0, 0}, 1, 1'b1, "simul");
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rvalid_cnt != r0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL simul_no_read: rvalid beats=%0d state=%0d want 0 IDLE", rvalid_cnt - r0, dbg_state);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [BEAT_W-1:0] b[4];
    sync();
    for (int i = 0; i < 2; i++) begin
      bus.bmem_write = 1'b1;
      bus.bmem_wdata = rand_beat();
      bus.bmem_addr  = 32'h0000_5000;
      @(posedge clk);
      #1;
    end
    bus.bmem_write = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.bmem_ready !== 1'b1 || bus.bmem_rvalid !== 1'b0 || bus.bmem_rdata !== '0 ||
        bus.bmem_raddr !== 32'd0 || bus.line_req !== 1'b0 || bus.line_we !== 1'b0 ||
        bus.line_addr !== 32'd0 || bus.line_wdata !== '0 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL midreset_outputs: ready=%0b rvalid=%0b rdata=%h raddr=%h req=%0b we=%0b laddr=%h state=%0d",
               bus.bmem_ready, bus.bmem_rvalid, bus.bmem_rdata, bus.bmem_raddr, bus.line_req,
               bus.line_we, bus.line_addr, dbg_state);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) b[i] = rand_beat();
    do_write(32'h0000_5000, b, '{0, 0, 0, 0}, 0, 1'b0, "midreset_new");
  endtask

  task automatic test_random();
    logic [BEAT_W-1:0] b[4];
    logic [31:0] addr;
    int g[4];
    for (int t = 0; t < 24; t++) begin
      addr = 32'h0000_3000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31));
      sync();
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 4; i++) begin
          b[i] = rand_beat();
          g[i] = $urandom_range(0, 2);
        end
        do_write(addr, b, g, $urandom_range(0, 3), 1'b0, "rand_write");
      end else begin
        do_read(addr, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                "rand_read");
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BEAT_W-1:0] b[4];
    for (int i = 0; i < 4; i++) b[i] = rand_beat();
    sync();
    do_write(32'h0000_6020, b, '{0, 0, 0, 0}, 0, 1'b0, "b2b_write");
    do_read(32'h0000_6028, 0, 0, 1'b1, "b2b_read");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence / report ----------------
  initial begin
    bus.bmem_addr   = '0;
    bus.bmem_read   = 1'b0;
    bus.bmem_write  = 1'b0;
    bus.bmem_wdata  = '0;
    bus.line_gnt    = 1'b0;
    bus.line_rvalid = 1'b0;
    bus.line_rdata  = rand_line();
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d beats left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
